alarm_clock: RTL and testbench

24-hour HH:MM clock with a settable alarm, driving a 4-digit multiplexed common-anode seven-segment display. A parameterised prescaler derives the 1 s tick from the system clock. Two push-buttons set the time or the alarm, selected by a 2-bit mode input. It is the top-level timekeeping block of the board design, and its seg/an outputs go straight to the display pins.

---
 rtl/alarm_clock_pkg.sv | 63 ++++++
 rtl/seg7_scan.sv | 65 ++++++
 rtl/alarm_clock.sv | 173 +++++++++++++++++
 tb/tb_alarm_clock.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_clock_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alarm_clock_pkg
//  Description : Shared definitions for the alarm clock: mode encodings,
//                active-low seven-segment patterns, the BCD digit type and
//                small helpers for decoding and binary-to-BCD splitting.
//  Revision    : 1.0 - initial release
// ============================================================================
package alarm_clock_pkg;

    typedef logic [3:0] bcd_t;

    localparam logic [1:0] MODE_RUN        = 2'd0;
    localparam logic [1:0] MODE_SET_TIME   = 2'd1;
    localparam logic [1:0] MODE_SET_ALARM  = 2'd2;
    localparam logic [1:0] MODE_SHOW_ALARM = 2'd3;

    // Active-low patterns, bit 0 = segment a ... bit 6 = segment g
    localparam logic [6:0] c_SEG_0     = 7'b1000000;
    localparam logic [6:0] c_SEG_1     = 7'b1111001;
    localparam logic [6:0] c_SEG_2     = 7'b0100100;
    localparam logic [6:0] c_SEG_3     = 7'b0110000;
    localparam logic [6:0] c_SEG_4     = 7'b0011001;
    localparam logic [6:0] c_SEG_5     = 7'b0010010;
    localparam logic [6:0] c_SEG_6     = 7'b0000010;
    localparam logic [6:0] c_SEG_7     = 7'b1111000;
    localparam logic [6:0] c_SEG_8     = 7'b0000000;
    localparam logic [6:0] c_SEG_9     = 7'b0010000;
    localparam logic [6:0] c_SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] seg_decode(input bcd_t d);
        logic [6:0] p;
        case (d)
            4'd0:    p = c_SEG_0;
            4'd1:    p = c_SEG_1;
            4'd2:    p = c_SEG_2;
            4'd3:    p = c_SEG_3;
            4'd4:    p = c_SEG_4;
            4'd5:    p = c_SEG_5;
            4'd6:    p = c_SEG_6;
            4'd7:    p = c_SEG_7;
            4'd8:    p = c_SEG_8;
            4'd9:    p = c_SEG_9;
            default: p = c_SEG_BLANK;
        endcase
        return p;
    endfunction

    // Values here never exceed 59, so both results fit a single BCD digit
    function automatic bcd_t bcd_tens(input logic [5:0] v);
        logic [5:0] q;
        q = v / 6'd10;
        return q[3:0];
    endfunction

    function automatic bcd_t bcd_units(input logic [5:0] v);
        logic [5:0] r;
        r = v % 6'd10;
        return r[3:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_scan.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan
//  Description : Four-digit multiplexed common-anode display driver. A
//                refresh counter advances a scan index every REFRESH_DIV
//                cycles; the same registered index drives both the anode
//                select and the digit decoder so an and seg never skew.
//  Ports       : clk, clr (async active-low reset)
//                i_dig3..i_dig0 : BCD digits, i_dig3 = leftmost (hour tens)
//                seg            : active-low segments, seg[0]=a .. seg[6]=g
//                an             : active-low anodes, an[0] = i_dig0
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan
    import alarm_clock_pkg::*;
#(
    parameter int REFRESH_DIV = 100_000
) (
    input  logic       clk,
    input  logic       clr,
    input  bcd_t       i_dig3,
    input  bcd_t       i_dig2,
    input  bcd_t       i_dig1,
    input  bcd_t       i_dig0,
    output logic [6:0] seg,
    output logic [3:0] an
);

    localparam int c_REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [c_REF_W-1:0] c_REF_LAST = c_REF_W'(REFRESH_DIV - 1);

    logic [c_REF_W-1:0] r_ref_cnt;
    logic [1:0]         r_scan_idx;
    logic               w_ref_wrap;
    bcd_t               w_digit;

    assign w_ref_wrap = (r_ref_cnt == c_REF_LAST);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_ref_cnt  <= '0;
            r_scan_idx <= 2'd0;
        end else if (w_ref_wrap) begin
            r_ref_cnt  <= '0;
            r_scan_idx <= r_scan_idx + 2'd1;
        end else begin
            r_ref_cnt  <= r_ref_cnt + 1'b1;
        end
    end

    always_comb begin
        w_digit = i_dig0;
        case (r_scan_idx)
            2'd0:    w_digit = i_dig0;
            2'd1:    w_digit = i_dig1;
            2'd2:    w_digit = i_dig2;
            default: w_digit = i_dig3;
        endcase
    end

    assign an  = ~(4'b0001 << r_scan_idx);
    assign seg = seg_decode(w_digit);

endmodule
`default_nettype wire

// File: rtl/alarm_clock.sv
`default_nettype none
// ============================================================================
//  Module      : alarm_clock
//  Description : 24-hour HH:MM:SS clock with settable alarm and a 4-digit
//                multiplexed seven-segment display. A prescaler produces the
//                1 s tick; two synchronised, edge-detected buttons set the
//                time (mode 1) or the alarm (mode 2).
//  Ports       : clk      system clock
//                clr      async active-low reset
//                mode     0 run/time, 1 set time, 2 set alarm, 3 run/alarm
//                min_up   minute button (asynchronous, active-high)
//                hour_up  hour button (asynchronous, active-high)
//                seg, an  display drive (active-low)
//                alarm    alarm indicator (active-high, registered)
//  Revision    : 1.0 - initial release
// ============================================================================
module alarm_clock
    import alarm_clock_pkg::*;
#(
    parameter int TICK_DIV    = 100_000_000,
    parameter int REFRESH_DIV = 100_000
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [1:0] mode,
    input  logic       min_up,
    input  logic       hour_up,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       alarm
);

    localparam int c_TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(TICK_DIV - 1);

    logic [c_TICK_W-1:0] r_presc;
    logic [1:0]          r_min_sync;
    logic [1:0]          r_hour_sync;
    logic                r_min_prev;
    logic                r_hour_prev;
    logic [5:0]          r_sec;
    logic [5:0]          r_min;
    logic [4:0]          r_hour;
    logic [5:0]          r_al_min;
    logic [4:0]          r_al_hour;
    logic                r_armed;
    logic                r_alarm;
    logic                r_show_alarm;

    logic                w_set_time;
    logic                w_set_alarm;
    logic                w_tick;
    logic                w_min_edge;
    logic                w_hour_edge;
    logic [5:0]          w_disp_min;
    logic [5:0]          w_disp_hour;

    assign w_set_time  = (mode == MODE_SET_TIME);
    assign w_set_alarm = (mode == MODE_SET_ALARM);
    assign w_tick      = !w_set_time && (r_presc == c_TICK_LAST);

    // Prescaler is parked at 0 while setting the time so the first second
    // after leaving mode 1 is a full TICK_DIV cycles long.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_presc <= '0;
        end else if (w_set_time || w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // Two-flop synchronisers plus one extra stage for rising-edge detect:
    // input rise -> edge pulse visible after 2 clocks -> counter update on 3rd.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_min_sync  <= 2'b00;
            r_hour_sync <= 2'b00;
            r_min_prev  <= 1'b0;
            r_hour_prev <= 1'b0;
        end else begin
            r_min_sync  <= {r_min_sync[0], min_up};
            r_hour_sync <= {r_hour_sync[0], hour_up};
            r_min_prev  <= r_min_sync[1];
            r_hour_prev <= r_hour_sync[1];
        end
    end

    assign w_min_edge  = r_min_sync[1]  && !r_min_prev;
    assign w_hour_edge = r_hour_sync[1] && !r_hour_prev;

    // Current time. Setting minutes does not carry into hours.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_sec  <= 6'd0;
            r_min  <= 6'd0;
            r_hour <= 5'd0;
        end else if (w_set_time) begin
            if (w_min_edge) begin
                r_min <= (r_min == 6'd59) ? 6'd0 : r_min + 6'd1;
                r_sec <= 6'd0;
            end
            if (w_hour_edge) begin
                r_hour <= (r_hour == 5'd23) ? 5'd0 : r_hour + 5'd1;
            end
        end else if (w_tick) begin
            if (r_sec == 6'd59) begin
                r_sec <= 6'd0;
                if (r_min == 6'd59) begin
                    r_min  <= 6'd0;
                    r_hour <= (r_hour == 5'd23) ? 5'd0 : r_hour + 5'd1;
                end else begin
                    r_min <= r_min + 6'd1;
                end
            end else begin
                r_sec <= r_sec + 6'd1;
            end
        end
    end

    // Alarm time; once any increment happens the alarm stays armed until reset.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_al_min  <= 6'd0;
            r_al_hour <= 5'd0;
            r_armed   <= 1'b0;
        end else if (w_set_alarm) begin
            if (w_min_edge) begin
                r_al_min <= (r_al_min == 6'd59) ? 6'd0 : r_al_min + 6'd1;
            end
            if (w_hour_edge) begin
                r_al_hour <= (r_al_hour == 5'd23) ? 5'd0 : r_al_hour + 5'd1;
            end
            if (w_min_edge || w_hour_edge) begin
                r_armed <= 1'b1;
            end
        end
    end

    // Alarm output and display source selection are both registered so a
    // mode change is seen on the next clock edge.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_alarm      <= 1'b0;
            r_show_alarm <= 1'b0;
        end else begin
            r_alarm      <= r_armed && (r_hour == r_al_hour) &&
                            (r_min == r_al_min) && !w_set_alarm;
            r_show_alarm <= (mode == MODE_SET_ALARM) || (mode == MODE_SHOW_ALARM);
        end
    end

    assign alarm = r_alarm;

    assign w_disp_min  = r_show_alarm ? r_al_min : r_min;
    assign w_disp_hour = r_show_alarm ? {1'b0, r_al_hour} : {1'b0, r_hour};

    seg7_scan #(
        .REFRESH_DIV (REFRESH_DIV)
    ) u_scan (
        .clk    (clk),
        .clr    (clr),
        .i_dig3 (bcd_tens(w_disp_hour)),
        .i_dig2 (bcd_units(w_disp_hour)),
        .i_dig1 (bcd_tens(w_disp_min)),
        .i_dig0 (bcd_units(w_disp_min)),
        .seg    (seg),
        .an     (an)
    );

endmodule
`default_nettype wire

// File: tb/tb_alarm_clock.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alarm_clock
//  Description : Self-checking bench for alarm_clock. A behavioural model
//                keeps time as seconds-of-day, pushes the expected an/seg/
//                alarm for every clock into a scoreboard queue, and a monitor
//                pops and compares on the falling edge. Directed scenarios
//                are followed by a randomized phase.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alarm_clock;

    localparam int TICK_DIV    = 4;
    localparam int REFRESH_DIV = 2;

    logic       clk     = 1'b0;
    logic       clr     = 1'b0;
    logic [1:0] mode    = 2'd0;
    logic       min_up  = 1'b0;
    logic       hour_up = 1'b0;
    logic [6:0] seg;
    logic [3:0] an;
    logic       alarm;

    alarm_clock #(
        .TICK_DIV    (TICK_DIV),
        .REFRESH_DIV (REFRESH_DIV)
    ) dut (
        .clk     (clk),
        .clr     (clr),
        .mode    (mode),
        .min_up  (min_up),
        .hour_up (hour_up),
        .seg     (seg),
        .an      (an),
        .alarm   (alarm)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [6:0] exp_seg(input int d);
        logic [6:0] tab [10];
        tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        if (d >= 0 && d < 10) return tab[d];
        return 7'b1111111;
    endfunction

    // ---------------- reference model + scoreboard producer ----------------
    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       alarm;
    } exp_t;

    exp_t sb_q[$];

    int m_tod, m_phase, m_al_min, m_al_hour, m_cycles;
    int m_min_wait, m_hour_wait;
    bit m_armed, m_alarm, m_show_alarm, m_min_prev, m_hour_prev;

    always @(posedge clk or negedge clr) begin
        int   hh, mm, idx, sh, sm, digit;
        bit   next_alarm, apply_min, apply_hour;
        exp_t e;
        if (!clr) begin
            m_tod = 0; m_phase = 0; m_al_min = 0; m_al_hour = 0; m_cycles = 0;
            m_min_wait = 0; m_hour_wait = 0;
            m_armed = 0; m_alarm = 0; m_show_alarm = 0;
            m_min_prev = 0; m_hour_prev = 0;
            sb_q.delete();
        end else begin
            hh = m_tod / 3600;
            mm = (m_tod / 60) % 60;
            next_alarm = m_armed && (hh == m_al_hour) && (mm == m_al_min) && (mode != 2'd2);

            // A press lands on the third clock edge after the input rises.
            apply_min = 0;
            apply_hour = 0;
            if (m_min_wait > 0) begin m_min_wait--; apply_min = (m_min_wait == 0); end
            if (m_hour_wait > 0) begin m_hour_wait--; apply_hour = (m_hour_wait == 0); end
            if (min_up && !m_min_prev) m_min_wait = 2;
            if (hour_up && !m_hour_prev) m_hour_wait = 2;
            m_min_prev = min_up;
            m_hour_prev = hour_up;

            if (mode == 2'd1) begin
                m_phase = 0;
                if (apply_min) m_tod = hh * 3600 + ((mm + 1) % 60) * 60;
                if (apply_hour) m_tod = ((m_tod / 3600 + 1) % 24) * 3600 + m_tod % 3600;
            end else begin
                m_phase++;
                if (m_phase == TICK_DIV) begin
                    m_phase = 0;
                    m_tod = (m_tod + 1) % 86400;
                end
                if (mode == 2'd2) begin
                    if (apply_min) begin m_al_min = (m_al_min + 1) % 60; m_armed = 1; end
                    if (apply_hour) begin m_al_hour = (m_al_hour + 1) % 24; m_armed = 1; end
                end
            end

            m_alarm = next_alarm;
            m_show_alarm = (mode >= 2'd2);
            m_cycles++;

            sh = m_show_alarm ? m_al_hour : m_tod / 3600;
            sm = m_show_alarm ? m_al_min : (m_tod / 60) % 60;
            idx = (m_cycles / REFRESH_DIV) % 4;
            case (idx)
                0: digit = sm % 10;
                1: digit = sm / 10;
                2: digit = sh % 10;
                default: digit = sh / 10;
            endcase
            e.an = 4'(~(4'b0001 << idx));
            e.seg = exp_seg(digit);
            e.alarm = m_alarm;
            sb_q.push_back(e);
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t e;
        if (clr) begin
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("scoreboard{an,seg,alarm}", int'({an, seg, alarm}), int'(e));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_mode(input logic [1:0] m);
        @(negedge clk);
        mode = m;
    endtask

    task automatic press(input bit do_min, input bit do_hour, input int hold);
        @(negedge clk);
        min_up = do_min;
        hour_up = do_hour;
        repeat (hold) @(negedge clk);
        min_up = 1'b0;
        hour_up = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2 clr = 1'b0;
        #1;
        chk("reset_an", int'(an), int'(4'b1110));
        chk("reset_seg", int'(seg), int'(7'b1000000));
        chk("reset_alarm", int'(alarm), 0);
        @(negedge clk);
        clr = 1'b1;
    endtask

    // Walks one full scan and compares every lit digit against HH:MM.
    task automatic check_disp(input int h, input int m);
        int d;
        repeat (4 * REFRESH_DIV) begin
            @(negedge clk);
            case (an)
                4'b1110: d = m % 10;
                4'b1101: d = m / 10;
                4'b1011: d = h % 10;
                4'b0111: d = h / 10;
                default: d = -1;
            endcase
            chk($sformatf("disp_%02d%02d_an%b", h, m, an), int'(seg), int'(exp_seg(d)));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        bit [1:0] r;
        // Reset and scan order
        #1;
        chk("init_an", int'(an), int'(4'b1110));
        chk("init_seg", int'(seg), int'(7'b1000000));
        chk("init_alarm", int'(alarm), 0);
        @(negedge clk);
        clr = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk("scan_order", int'(an), int'(4'(~(4'b0001 << ((k / REFRESH_DIV) % 4)))));
        end

        // 60+ ticks in mode 0: minute units reads 1
        wait_cycles(240);
        n = 0;
        while (an != 4'b1110 && n < 8) begin @(negedge clk); n++; end
        chk("run_min_units_an", int'(an), int'(4'b1110));
        chk("run_min_units_seg", int'(seg), int'(7'b1111001));

        // Mid-run reset, then set-time scenarios
        pulse_reset();
        set_mode(2'd1);
        press(1, 0, 1);
        press(1, 0, 1);
        check_disp(0, 2);
        wait_cycles(40);
        check_disp(0, 2);
        press(1, 0, 50);
        check_disp(0, 3);
        press(1, 1, 2);
        check_disp(1, 4);
        repeat (22) press(0, 1, 1);
        check_disp(23, 4);
        press(0, 1, 1);
        check_disp(0, 4);
        repeat (23) press(0, 1, 1);
        repeat (55) press(1, 0, 1);
        check_disp(23, 59);

        // Run through midnight
        set_mode(2'd0);
        wait_cycles(250);
        set_mode(2'd1);
        check_disp(0, 0);

        // Set alarm while the clock runs, then back to time display
        set_mode(2'd2);
        press(0, 1, 1);
        press(1, 0, 1);
        press(1, 0, 1);
        check_disp(1, 2);
        set_mode(2'd0);
        check_disp(0, 0);

        // Alarm match window
        pulse_reset();
        set_mode(2'd2);
        press(1, 0, 1);
        set_mode(2'd0);
        n = 0;
        while (!alarm && n < 400) begin @(negedge clk); n++; end
        chk("alarm_rise", int'(alarm), 1);
        wait_cycles(20);
        set_mode(2'd2);
        @(negedge clk);
        chk("alarm_drop_mode2", int'(alarm), 0);
        set_mode(2'd3);
        @(negedge clk);
        chk("alarm_back_mode3", int'(alarm), 1);
        n = 0;
        while (alarm && n < 400) begin @(negedge clk); n++; end
        chk("alarm_fall", int'(alarm), 0);

        // Randomized phase, checked by the scoreboard
        pulse_reset();
        for (int it = 0; it < 80; it++) begin
            set_mode(2'($urandom_range(0, 3)));
            r = 2'($urandom_range(0, 3));
            if (r != 2'd0) press(r[0], r[1], $urandom_range(1, 6));
            wait_cycles($urandom_range(0, 20));
        end

        wait_cycles(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
